accumulator_binary_saturating: RTL and testbench
================================================

# accumulator_binary_saturating

Registered signed accumulator that applies a stream of add, subtract, load and hold operations to a running total. The total is clipped to runtime `max_limit`/`min_limit`, and each updated total is presented downstream with its limit flags over a valid/ready handshake. The block is the stateful consumer of saturating add/subtract arithmetic: it feeds its own result back as the A operand each cycle. It is used for counters, integrators and credit trackers that must never wrap.

## Interface
- `WORD_WIDTH`, default 0 (must be set, ≥2): width of accumulator, operands and limits, two's-complement signed.
- `RESET_VALUE`, default 0: accumulator value after reset, WORD_WIDTH bits, not clipped.
- `clock`  in  1  single clock; all state on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset; release synchronised externally.
- `max_limit`  in  WORD_WIDTH  signed upper clip bound, inclusive; sampled on input accept.
- `min_limit`  in  WORD_WIDTH  signed lower clip bound, inclusive; must satisfy max_limit ≥ min_limit (signed), otherwise results are undefined.
- `input_valid`  in  1  operation offered.
- `input_ready`  out  1  operation accepted when valid and ready are both high.
- `input_op`  in  2  operation: 00 add, 01 subtract, 10 load, 11 hold.
- `input_carry`  in  1  carry-in for add/subtract; ignored for load/hold.
- `input_operand`  in  WORD_WIDTH  B operand (add/sub) or load value.
- `output_valid`  out  1  result available.
- `output_ready`  in  1  downstream accepts result.
- `output_total`  out  WORD_WIDTH  accumulator value after the accepted operation.
- `output_carry`  out  1  unsigned carry-out of the WORD_WIDTH add/sub before clipping; 0 for load/hold.
- `output_at_max`, `output_over_max`, `output_at_min`, `output_under_min`  out  1 each  limit flags for the pre-clip result.

## Operation
- Arithmetic is computed on WORD_WIDTH+1 bits with acc and operand sign-extended, so no overflow is possible.
- Add: r = acc + operand + carry. Subtract: r = acc − operand − carry, computed as acc + ~operand + ~carry with WORD_WIDTH+1 borrow semantics. `carry_in=1` on subtract removes one extra unit.
- Load: r = sign-extended operand.
- Hold: r = acc. Hold re-emits the total with fresh flags against the current limits.
- Flags use signed comparisons on WORD_WIDTH+1 bits: at_max = (r == max), over_max = (r > max), at_min = (r == min), under_min = (r < min).
- Clipping: if over_max, new acc = max_limit; else if under_min, new acc = min_limit; else new acc = r[WORD_WIDTH-1:0]. Load and hold are clipped the same way.
- acc updates only on input accept. output_total always equals acc.
- output_carry is the carry into bit WORD_WIDTH of the extended sum: A[msb] ^ B'[msb] ^ r[msb], where B' is the operand as applied (inverted for subtract).

## Timing
- Reset (async assert): acc = RESET_VALUE, output_valid = 0, output_carry = 0, all flags = 0. input_ready = 1 once reset_n is high.
- One-entry output register. input_ready = !output_valid || output_ready, purely combinational from output_ready.
- Latency 1: an operation accepted at edge N gives output_valid = 1 with its total and flags after edge N.
- Throughput: 1 op/cycle while output_ready is held high.
- Simultaneous output accept and input accept in the same cycle: the register is overwritten with the new result and output_valid stays 1.
- Output accepted with no new input: output_valid drops to 0 next cycle, acc is retained, and flags hold their last values.
- While output_valid && !output_ready: output_total, output_carry and the flags are stable. The input is stalled. Limit changes have no effect until the next accept.
- reset_n asserted mid-stream: any pending result is discarded immediately and nothing is emitted for it.

## Test plan
WORD_WIDTH=8, RESET_VALUE=0, max=100, min=−50.
- Reset then hold, output_ready=1 -> next cycle total=0, all flags 0, valid=1 for one cycle.
- add 60, add 40, add 1 back-to-back -> totals 60, 100 (at_max=1), 100 (over_max=1); one result per cycle.
- load −40, sub 9 carry=1, sub 5 -> totals −40, −50 (at_min=1), −50 (under_min=1).
- load 127, add 127 with max=127, min=−128 -> r=254, total=127, over_max=1, output_carry=0. Then add 1 on load −1 -> carry=1, total=0.
- Hold output_ready=0 for 5 cycles after an add 10 -> input_ready=0, total stable at 10. The queued add 5 is accepted on the cycle ready rises, giving total 15.
- Drop reset_n while output_valid=1 -> output_valid=0 and total=0 immediately, with no clock edge required.

Source files
------------

// File: rtl/accumulator_binary_saturating.sv
// Saturating signed accumulator: add/sub/load/hold on a running total, clipped to
// runtime limits, with a one-entry valid/ready output register carrying the flags.
module accumulator_binary_saturating #(
    parameter int                    WORD_WIDTH  = 0,
    parameter logic [WORD_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [WORD_WIDTH-1:0] max_limit,
    input  logic [WORD_WIDTH-1:0] min_limit,
    input  logic                  input_valid,
    output logic                  input_ready,
    input  logic [1:0]            input_op,
    input  logic                  input_carry,
    input  logic [WORD_WIDTH-1:0] input_operand,
    output logic                  output_valid,
    input  logic                  output_ready,
    output logic [WORD_WIDTH-1:0] output_total,
    output logic                  output_carry,
    output logic                  output_at_max,
    output logic                  output_over_max,
    output logic                  output_at_min,
    output logic                  output_under_min
);
    localparam int W = WORD_WIDTH;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;

    logic [W-1:0] r_acc;
    logic         r_valid;
    logic         r_carry;
    logic         r_at_max, r_over_max, r_at_min, r_under_min;

    logic [W:0]   w_a, w_b, w_bop, w_r, w_max, w_min;
    logic [W:0]   w_cin;
    logic         w_carry, w_accept;
    logic         w_at_max, w_over_max, w_at_min, w_under_min;
    logic [W-1:0] w_next;

    assign input_ready = !r_valid || output_ready;
    assign w_accept    = input_valid && input_ready;

    assign w_a   = {r_acc[W-1], r_acc};
    assign w_b   = {input_operand[W-1], input_operand};
    assign w_max = {max_limit[W-1], max_limit};
    assign w_min = {min_limit[W-1], min_limit};

    // Subtract is acc + ~B + ~carry; the extra bit keeps every result exact.
    always_comb begin
        w_bop   = '0;
        w_cin   = '0;
        w_r     = w_a;
        w_carry = 1'b0;
        case (input_op)
            OP_ADD: begin
                w_bop   = w_b;
                w_cin   = {{W{1'b0}}, input_carry};
                w_r     = w_a + w_bop + w_cin;
                w_carry = w_a[W] ^ w_bop[W] ^ w_r[W];
            end
            OP_SUB: begin
                w_bop   = ~w_b;
                w_cin   = {{W{1'b0}}, ~input_carry};
                w_r     = w_a + w_bop + w_cin;
                w_carry = w_a[W] ^ w_bop[W] ^ w_r[W];
            end
            OP_LOAD: w_r = w_b;
            default: w_r = w_a;
        endcase
    end

    assign w_at_max    = (w_r == w_max);
    assign w_over_max  = ($signed(w_r) > $signed(w_max));
    assign w_at_min    = (w_r == w_min);
    assign w_under_min = ($signed(w_r) < $signed(w_min));

    always_comb begin
        w_next = w_r[W-1:0];
        if (w_over_max)       w_next = max_limit;
        else if (w_under_min) w_next = min_limit;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_acc       <= RESET_VALUE;
            r_valid     <= 1'b0;
            r_carry     <= 1'b0;
            r_at_max    <= 1'b0;
            r_over_max  <= 1'b0;
            r_at_min    <= 1'b0;
            r_under_min <= 1'b0;
        end else if (w_accept) begin
            r_acc       <= w_next;
            r_valid     <= 1'b1;
            r_carry     <= w_carry;
            r_at_max    <= w_at_max;
            r_over_max  <= w_over_max;
            r_at_min    <= w_at_min;
            r_under_min <= w_under_min;
        end else if (output_ready) begin
            // Drained with nothing new: total and flags keep their last values.
            r_valid <= 1'b0;
        end
    end

    assign output_valid     = r_valid;
    assign output_total     = r_acc;
    assign output_carry     = r_carry;
    assign output_at_max    = r_at_max;
    assign output_over_max  = r_over_max;
    assign output_at_min    = r_at_min;
    assign output_under_min = r_under_min;

endmodule

// File: tb/tb_accumulator_binary_saturating.sv
// Scoreboard bench: expectations are pushed on input accept and compared on output handshake.
module tb_accumulator_binary_saturating;
    localparam int W = 8;

    typedef struct {
        logic [7:0] total;
        logic       carry;
        logic [3:0] flags;   // {at_max, over_max, at_min, under_min}
    } exp_t;

    logic              clock = 1'b0;
    logic              reset_n;
    logic signed [7:0] max_limit, min_limit;
    logic              input_valid, input_ready;
    logic [1:0]        input_op;
    logic              input_carry;
    logic [7:0]        input_operand;
    logic              output_valid, output_ready;
    logic [7:0]        output_total;
    logic              output_carry;
    logic              output_at_max, output_over_max, output_at_min, output_under_min;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];
    logic [7:0] m_acc;
    logic       done;

    accumulator_binary_saturating #(.WORD_WIDTH(W), .RESET_VALUE(8'd0)) dut (
        .clock(clock), .reset_n(reset_n),
        .max_limit(max_limit), .min_limit(min_limit),
        .input_valid(input_valid), .input_ready(input_ready),
        .input_op(input_op), .input_carry(input_carry), .input_operand(input_operand),
        .output_valid(output_valid), .output_ready(output_ready),
        .output_total(output_total), .output_carry(output_carry),
        .output_at_max(output_at_max), .output_over_max(output_over_max),
        .output_at_min(output_at_min), .output_under_min(output_under_min)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic c, input logic [7:0] opnd);
        exp_t e;
        int a, b, r, mx, mn, u;
        a  = int'($signed(m_acc));
        b  = int'($signed(opnd));
        mx = int'(max_limit);
        mn = int'(min_limit);
        e.carry = 1'b0;
        case (op)
            2'd0: begin
                r = a + b + int'(c);
                u = int'({1'b0, m_acc}) + int'({1'b0, opnd}) + int'(c);
                e.carry = (u > 255);
            end
            2'd1: begin
                r = a - b - int'(c);
                u = int'({1'b0, m_acc}) + int'({1'b0, ~opnd}) + int'(!c);
                e.carry = (u > 255);
            end
            2'd2:    r = b;
            default: r = a;
        endcase
        e.flags = {r == mx, r > mx, r == mn, r < mn};
        if (r > mx)      r = mx;
        else if (r < mn) r = mn;
        e.total = r[7:0];
        m_acc   = e.total;
        return e;
    endfunction

    // Offer one op, wait (bounded) for acceptance, record its expectation.
    task automatic do_op(input logic [1:0] op, input logic c, input logic [7:0] opnd, output int waited);
        int cnt = 0;
        input_op      = op;
        input_carry   = c;
        input_operand = opnd;
        input_valid   = 1'b1;
        @(negedge clock);
        while (!input_ready && cnt < 50) begin
            @(negedge clock);
            cnt++;
        end
        waited = cnt;
        if (!input_ready) chk("accept_timeout", 32'd0, 32'd1);
        else              sb.push_back(model(op, c, opnd));
        @(posedge clock);
        #1 input_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        output_ready = 1'b1;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clock);
            n++;
        end
        chk("drain_empty", sb.size(), 0);
        #1 chk("valid_drop", output_valid, 1'b0);
    endtask

    always @(negedge clock) begin
        if (reset_n && output_valid && output_ready) begin
            if (sb.size() == 0) chk("spurious_out", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("total", output_total, e.total);
                chk("carry", output_carry, e.carry);
                chk("flags", {output_at_max, output_over_max, output_at_min, output_under_min}, e.flags);
            end
        end
    end

    initial begin
        int w;
        reset_n = 1'b0;
        input_valid = 1'b0; input_op = 2'd3; input_carry = 1'b0; input_operand = '0;
        output_ready = 1'b1;
        max_limit = 8'sd100; min_limit = -8'sd50;
        m_acc = 8'd0;
        done = 1'b0;
        #12;
        chk("rst_valid", output_valid, 1'b0);
        chk("rst_total", output_total, 8'd0);
        chk("rst_carry", output_carry, 1'b0);
        chk("rst_flags", {output_at_max, output_over_max, output_at_min, output_under_min}, 4'd0);
        chk("rst_ready", input_ready, 1'b1);
        @(posedge clock);
        #1 reset_n = 1'b1;

        do_op(2'd3, 1'b0, 8'd0, w);
        drain();

        do_op(2'd0, 1'b0, 8'd60, w); chk("no_stall0", w, 0);
        do_op(2'd0, 1'b0, 8'd40, w); chk("no_stall1", w, 0);
        do_op(2'd0, 1'b0, 8'd1,  w); chk("no_stall2", w, 0);
        drain();

        do_op(2'd2, 1'b0, 8'hD8, w);   // load -40
        do_op(2'd1, 1'b1, 8'd9,  w);
        do_op(2'd1, 1'b0, 8'd5,  w);
        drain();

        max_limit = 8'sd127; min_limit = -8'sd128;
        do_op(2'd2, 1'b0, 8'd127, w);
        do_op(2'd0, 1'b0, 8'd127, w);
        do_op(2'd2, 1'b0, 8'hFF,  w);
        do_op(2'd0, 1'b0, 8'd1,   w);
        drain();
        max_limit = 8'sd100; min_limit = -8'sd50;

        do_op(2'd2, 1'b0, 8'd0, w);
        drain();
        output_ready = 1'b0;
        do_op(2'd0, 1'b0, 8'd10, w);
        fork
            do_op(2'd0, 1'b0, 8'd5, w);
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clock);
                    chk("stall_ready", input_ready, 1'b0);
                    chk("stall_total", output_total, 8'd10);
                    chk("stall_valid", output_valid, 1'b1);
                end
                @(posedge clock);
                #1 output_ready = 1'b1;
            end
        join
        drain();
        chk("after_stall_total", output_total, 8'd15);

        fork
            begin
                for (int i = 0; i < 40; i++)
                    do_op(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), w);
                done = 1'b1;
            end
            while (!done) begin
                @(posedge clock);
                #1 output_ready = 1'($urandom_range(0, 1));
            end
        join
        drain();

        output_ready = 1'b0;
        do_op(2'd2, 1'b0, 8'd20, w);
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_valid", output_valid, 1'b0);
        chk("async_rst_total", output_total, 8'd0);
        sb.delete();
        m_acc = 8'd0;
        @(posedge clock);
        #1 reset_n = 1'b1;
        output_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1 chk("post_rst_valid", output_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
